// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver for the 4-bit serial link.
// Assembles qualified serial bits into words behind a one-entry valid/ready holding register.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  input  logic             sync,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] nxt;
  logic [CW-1:0]    cnt;
  logic             take;
  logic             last;
  logic             free;
  logic             load;
  logic             drain;

  // next shift value, completion and holding-register handshake terms
  always_comb begin
    nxt   = LSB_FIRST ? {si, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], si};
    take  = si_en & ~sync;
    last  = (cnt == CW'(WIDTH-1));
    free  = ~po_valid | po_ready;
    load  = take & last & free;
    drain = po_valid & po_ready;
  end

  // shifter, bit counter, holding register and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      po       <= '0;
      po_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (sync) begin
        sh  <= '0;
        cnt <= '0;
      end else if (si_en) begin
        sh  <= nxt;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (load) begin
        po       <= nxt;
        po_valid <= 1'b1;
      end else if (drain) begin
        po_valid <= 1'b0;
      end
      if (take && last && !free) begin
        overrun <= 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver: the deserializing end of the team's 4-bit serial link, paired with the PISO transmitter. It reassembles WIDTH-bit words from a qualified serial bit stream and presents each completed word through a one-entry valid/ready holding register. It sits between the serial line and any parallel consumer, and flags words dropped because the consumer stalled.

## Interface
- WIDTH, 4: word width in bits; must be at least 2.
- LSB_FIRST, 1: 1 = first received bit lands in po[0] (matches the PISO shift order); 0 = first received bit lands in po[WIDTH-1].

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- si  input  1  serial data bit, sampled on a clk edge only when si_en=1.
- si_en  input  1  bit-valid qualifier; one bit is consumed per cycle with si_en=1.
- sync  input  1  frame restart; discards any partial word.
- po  output  WIDTH  last completed word; holding-register contents.
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po on an edge where po_valid=1.
- busy  output  1  partial word in progress (bit count != 0).
- overrun  output  1  sticky; a completed word was dropped.

## Operation
- Internal state: shift register sh[WIDTH-1:0], bit counter cnt in 0..WIDTH-1, holding register po plus po_valid, and overrun.
- Edge priority, highest first: rst > sync > si_en.
- rst: sh=0, cnt=0, po=0, po_valid=0, overrun=0. All inputs are ignored on that edge.
- sync=1: sh=0, cnt=0, and si_en is ignored on that edge. po, po_valid and overrun are unaffected; a po_ready handshake on the same edge still completes.
- Shift on si_en=1:
  - LSB_FIRST=1: sh <= {si, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], si}.
  - cnt increments.
- Completion: si_en=1 with cnt==WIDTH-1. The assembled word is the shifted value including the current si bit. cnt wraps to 0.
  - If the holding register is free (po_valid=0, or po_valid=1 with po_ready=1 on this edge): po <= word, po_valid <= 1.
  - Otherwise: the word is dropped, overrun <= 1, and po/po_valid are unchanged.
- Drain: po_valid=1 and po_ready=1 with no simultaneous load gives po_valid <= 0. po keeps its stale value.
- overrun clears only on rst.
- busy = (cnt != 0), combinational from registered cnt.

## Timing
- One bit per qualified cycle; gaps in si_en are allowed indefinitely with no state change.
- Latency: po/po_valid update on the same edge that samples the final bit. They are visible in the cycle after the WIDTH-th qualified edge; no extra pipeline stage.
- Throughput: back-to-back words at full rate (WIDTH cycles per word) without overrun, provided po_ready=1 on each completion edge.
- po_ready is ignored while po_valid=0.
- po is stable while po_valid=1 and not yet accepted.
- Reset values: po=0, po_valid=0, busy=0, overrun=0.
- Reset mid-word: the partial word is lost and the next qualified bit is bit 0 of a new word.
- Reset with po_valid=1: the held word is lost, no handshake completes, and overrun is not set.
- Simultaneous completion and drain: the old word is accepted and the new word loads on the same edge; po_valid stays 1 and no overrun is flagged.
- No combinational path from any input to any output.

## Test plan
- Basic LSB_FIRST=1: rst, then si=1,0,1,1 on 4 consecutive si_en=1 cycles with po_ready=0 -> po=4'b1101, po_valid=1 after the 4th edge, busy=0, overrun=0.
- Gapped input and MSB order (LSB_FIRST=0): bits 1,1,0,1 with si_en deasserted for 3 cycles between bits 2 and 3 -> po=4'b1101, busy=1 during the gap, po_valid rises only after the 4th qualified bit.
- Overrun: po_ready=0; send word 4'b0011 then word 4'b1111 -> po stays 4'b0011, po_valid=1, overrun=1. Assert po_ready one cycle -> po_valid=0, overrun stays 1.
- Simultaneous drain and load: po_valid=1 holding 4'b0101; complete 4'b1010 with po_ready=1 on the final-bit edge -> po=4'b1010, po_valid=1, overrun=0.
- sync mid-word: send 2 bits (1,1), pulse sync with si_en=1 and si=1 on the same edge, then send 0,1,1,0 (LSB first) -> po=4'b0110, and no word forms from the first two bits.
- Reset mid-operation: po_valid=1 and 3 bits into the next word, assert rst 1 cycle -> all outputs 0. A following 4-bit word 1,0,0,0 -> po=4'b0001.
